// File: rtl/intra_pkg.sv
// -----------------------------------------------------------------------------
// intra_pkg
// Shared types and helpers for the intra mode savers (4x4 / 8x8 / 16x16).
//   state_t      : saver FSM state encoding (also exported for debug)
//   MODE_*       : intra prediction mode numbers
//   clog2_min1() : ceil(log2(v)) clamped to at least 1, for port widths
// -----------------------------------------------------------------------------
package intra_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int MODE_VER   = 0;
   localparam int MODE_HOR   = 1;
   localparam int MODE_DC    = 2;
   localparam int MODE_PLANE = 3;

   // A one-value range still needs a 1-bit signal, so never return 0.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/intra_sad_argmin.sv
// -----------------------------------------------------------------------------
// intra_sad_argmin
// Sequential masked argmin over NMODES SAD candidates, one candidate per cycle.
// start_i latches the candidate set and begins a scan of NMODES cycles.
// A candidate replaces the running best only when it is enabled and strictly
// smaller, so ties keep the lowest mode index. With no enabled candidate the
// result falls back to DEFAULT_MODE and its SAD.
//
// Ports
//   clk, reset    : clock, asynchronous active-low reset
//   start_i       : load sads_i/mask_i and start scanning (must not overlap a scan)
//   sads_i        : SAD of mode m at [m*SAD_W +: SAD_W]
//   mask_i        : bit m set when mode m is available
//   last_o        : high during the final scan cycle
//   fin_mode_o    : result including the current candidate (valid with last_o)
//   fin_sad_o     : SAD matching fin_mode_o
//   mode_o/sad_o  : registered result of the most recent completed scan
// -----------------------------------------------------------------------------
module intra_sad_argmin
   import intra_pkg::*;
#(
   parameter  int NMODES       = 4,
   parameter  int SAD_W        = 16,
   parameter  int DEFAULT_MODE = MODE_DC,
   localparam int MODE_W       = clog2_min1(NMODES)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic [NMODES*SAD_W-1:0]   sads_i,
   input  logic [NMODES-1:0]         mask_i,
   output logic                      last_o,
   output logic [MODE_W-1:0]         fin_mode_o,
   output logic [SAD_W-1:0]          fin_sad_o,
   output logic [MODE_W-1:0]         mode_o,
   output logic [SAD_W-1:0]          sad_o
);

   localparam logic [MODE_W-1:0] LAST_K  = MODE_W'(NMODES - 1);
   localparam logic [MODE_W-1:0] DEF_MODE = MODE_W'(DEFAULT_MODE);

   logic [NMODES*SAD_W-1:0] sads_q;
   logic [NMODES-1:0]       mask_q;
   logic [MODE_W-1:0]       k_q;
   logic                    busy_q;
   logic                    have_q;
   logic [MODE_W-1:0]       best_mode_q;
   logic [SAD_W-1:0]        best_sad_q;
   logic [MODE_W-1:0]       mode_q;
   logic [SAD_W-1:0]        sad_q;

   logic [SAD_W-1:0]        cand_sad;
   logic                    take;
   logic [MODE_W-1:0]       best_mode_d;
   logic [SAD_W-1:0]        best_sad_d;
   logic                    have_d;

   always_comb begin
      cand_sad    = sads_q[int'(k_q)*SAD_W +: SAD_W];
      take        = mask_q[k_q] && (!have_q || (cand_sad < best_sad_q));
      best_mode_d = take ? k_q : best_mode_q;
      best_sad_d  = take ? cand_sad : best_sad_q;
      have_d      = have_q | take;
      fin_mode_o  = have_d ? best_mode_d : DEF_MODE;
      fin_sad_o   = have_d ? best_sad_d  : sads_q[DEFAULT_MODE*SAD_W +: SAD_W];
      last_o      = busy_q && (k_q == LAST_K);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sads_q      <= '0;
         mask_q      <= '0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         have_q      <= 1'b0;
         best_mode_q <= '0;
         best_sad_q  <= '0;
         mode_q      <= '0;
         sad_q       <= '0;
      end else if (start_i) begin
         sads_q <= sads_i;
         mask_q <= mask_i;
         k_q    <= '0;
         busy_q <= 1'b1;
         have_q <= 1'b0;
      end else if (busy_q) begin
         best_mode_q <= best_mode_d;
         best_sad_q  <= best_sad_d;
         have_q      <= have_d;
         k_q         <= k_q + 1'b1;
         if (k_q == LAST_K) begin
            busy_q <= 1'b0;
            mode_q <= fin_mode_o;
            sad_q  <= fin_sad_o;
         end
      end
   end

   assign mode_o = mode_q;
   assign sad_o  = sad_q;

endmodule

// File: rtl/intra_mode_saver.sv
// -----------------------------------------------------------------------------
// intra_mode_saver
// Per block: picks the lowest-SAD available prediction mode, streams the chosen
// residue block into the frame residue memory one row per cycle, and records
// the mode in a per-block mode table.
//
// Handshake: a block is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. sads/mode_mask/mbnumber are captured at
// acceptance; res is NOT captured and must stay stable until done.
//
// Ports
//   clk, reset         : clock, asynchronous active-low reset
//   in_valid/in_ready  : block candidate set handshake
//   sads, mode_mask    : per-mode SADs and availability
//   res                : per-mode residue, pixel p=r*BLK+c of mode m at
//                        [(m*BLK*BLK+p)*PIX_W +: PIX_W]
//   mbnumber           : raster block index (one spare bit for range errors)
//   mem_we/addr/wdata  : residue row write port (row-major, BLK pixels/word)
//   done, err          : one-cycle completion pulse; err = mbnumber out of range
//   mode, min_sad      : selected mode and its SAD, held until the next done
//   mt_raddr/mt_rdata  : mode table read port, one cycle latency
//   dbg_state          : current FSM state
// -----------------------------------------------------------------------------
module intra_mode_saver
   import intra_pkg::*;
#(
   parameter  int BLK          = 8,
   parameter  int NMODES       = 4,
   parameter  int SAD_W        = 16,
   parameter  int PIX_W        = 8,
   parameter  int FRAME_W      = 256,
   parameter  int FRAME_H      = 256,
   parameter  int DEFAULT_MODE = MODE_DC,
   localparam int MB_COLS      = FRAME_W / BLK,
   localparam int MB_COUNT     = MB_COLS * (FRAME_H / BLK),
   localparam int MODE_W       = clog2_min1(NMODES),
   localparam int MB_W         = clog2_min1(MB_COUNT),
   localparam int ADDR_W       = clog2_min1(FRAME_H * MB_COLS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NMODES*SAD_W-1:0]           sads,
   input  logic [NMODES-1:0]                 mode_mask,
   input  logic [NMODES*BLK*BLK*PIX_W-1:0]   res,
   input  logic [MB_W:0]                     mbnumber,
   output logic                              mem_we,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic [BLK*PIX_W-1:0]              mem_wdata,
   output logic                              done,
   output logic [MODE_W-1:0]                 mode,
   output logic [SAD_W-1:0]                  min_sad,
   output logic                              err,
   input  logic [MB_W-1:0]                   mt_raddr,
   output logic [MODE_W-1:0]                 mt_rdata,
   output state_t                            dbg_state
);

   localparam int                ROW_W    = $clog2(BLK);
   localparam int                COL_W    = $clog2(MB_COLS);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(BLK - 1);
   localparam logic [MB_W:0]     MB_LIMIT = (MB_W + 1)'(MB_COUNT);
   localparam logic [MB_W:0]     COL_MASK = (MB_W + 1)'(MB_COLS - 1);

   state_t                state_q;
   logic [MB_W:0]         mb_q;
   logic [ROW_W-1:0]      row_q;
   logic                  err_q;
   logic [MODE_W-1:0]     mode_q;
   logic [SAD_W-1:0]      min_sad_q;
   logic [MODE_W-1:0]     mt_rdata_q;
   logic [MODE_W-1:0]     mt_q [MB_COUNT];

   logic                  am_start;
   logic                  am_last;
   logic [MODE_W-1:0]     am_fin_mode;
   logic [SAD_W-1:0]      am_fin_sad;
   logic [MODE_W-1:0]     am_mode;
   logic [SAD_W-1:0]      am_sad;

   assign am_start = (state_q == ST_IDLE) && in_valid;

   intra_sad_argmin #(
      .NMODES       (NMODES),
      .SAD_W        (SAD_W),
      .DEFAULT_MODE (DEFAULT_MODE)
   ) u_argmin (
      .clk        (clk),
      .reset      (reset),
      .start_i    (am_start),
      .sads_i     (sads),
      .mask_i     (mode_mask),
      .last_o     (am_last),
      .fin_mode_o (am_fin_mode),
      .fin_sad_o  (am_fin_sad),
      .mode_o     (am_mode),
      .sad_o      (am_sad)
   );

   // Main FSM. mode/min_sad are loaded on the edge entering DONE so they are
   // valid with the done pulse and hold until the next one. On the error path
   // the argmin result register updates on that same edge, so its
   // combinational final value is taken instead.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         mb_q      <= '0;
         row_q     <= '0;
         err_q     <= 1'b0;
         mode_q    <= '0;
         min_sad_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  mb_q    <= mbnumber;
                  err_q   <= 1'b0;
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (am_last) begin
                  row_q <= '0;
                  if (mb_q >= MB_LIMIT) begin
                     err_q     <= 1'b1;
                     mode_q    <= am_fin_mode;
                     min_sad_q <= am_fin_sad;
                     state_q   <= ST_DONE;
                  end else begin
                     state_q <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               row_q <= row_q + 1'b1;
               if (row_q == ROW_LAST) begin
                  mode_q    <= am_mode;
                  min_sad_q <= am_sad;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Address = (by*BLK + r)*MB_COLS + bx. All factors are powers of two, so
   // the fields are disjoint and can be assembled with shifts and ORs.
   logic [ADDR_W-1:0]     by_a;
   logic [ADDR_W-1:0]     bx_a;
   logic [ADDR_W-1:0]     row_a;
   logic [ADDR_W-1:0]     addr_c;
   logic [BLK*PIX_W-1:0]  row_c;

   always_comb begin
      by_a   = ADDR_W'(mb_q >> COL_W);
      bx_a   = ADDR_W'(mb_q & COL_MASK);
      row_a  = ADDR_W'(row_q);
      addr_c = (((by_a << ROW_W) | row_a) << COL_W) | bx_a;
      row_c  = res[(int'(am_mode) * BLK * BLK + int'(row_q) * BLK) * PIX_W +: BLK * PIX_W];
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign mem_we    = (state_q == ST_WRITE);
   assign mem_addr  = mem_we ? addr_c : '0;
   assign mem_wdata = mem_we ? row_c : '0;
   assign done      = (state_q == ST_DONE);
   assign err       = done & err_q;
   assign mode      = mode_q;
   assign min_sad   = min_sad_q;
   assign dbg_state = state_q;

   // Mode table storage: no reset, only written entries are meaningful.
   always_ff @(posedge clk) begin
      if ((state_q == ST_DONE) && !err_q) begin
         mt_q[mb_q[MB_W-1:0]] <= mode_q;
      end
   end

   // Registered read port; a same-cycle write is not forwarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mt_rdata_q <= '0;
      end else begin
         mt_rdata_q <= mt_q[mt_raddr];
      end
   end

   assign mt_rdata = mt_rdata_q;

endmodule

// File: tb/tb_intra_mode_saver.sv
// -----------------------------------------------------------------------------
// tb_intra_mode_saver
// Self-checking bench for intra_mode_saver with default parameters
// (BLK=8, NMODES=4, 256x256 frame). Expected mode/SAD, row writes and mode
// table contents come from a behavioural model of the block's rules.
// -----------------------------------------------------------------------------
module tb_intra_mode_saver;

   localparam int NM       = 4;
   localparam int BLK      = 8;
   localparam int SAD_W    = 16;
   localparam int PIX_W    = 8;
   localparam int MB_COLS  = 32;
   localparam int MB_COUNT = 1024;
   localparam int MODE_W   = 2;
   localparam int MB_W     = 10;
   localparam int ADDR_W   = 13;
   localparam int ROW_BITS = BLK * PIX_W;
   localparam int RES_W    = NM * BLK * BLK * PIX_W;
   localparam int SBW      = ADDR_W + ROW_BITS;
   localparam int DEF_MODE = 2;

   // ---------------- clock / reset / DUT ----------------
   logic                    clk;
   logic                    reset;
   logic                    in_valid;
   logic                    in_ready;
   logic [NM*SAD_W-1:0]     sads;
   logic [NM-1:0]           mode_mask;
   logic [RES_W-1:0]        res;
   logic [MB_W:0]           mbnumber;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [ROW_BITS-1:0]     mem_wdata;
   logic                    done;
   logic [MODE_W-1:0]       mode;
   logic [SAD_W-1:0]        min_sad;
   logic                    err;
   logic [MB_W-1:0]         mt_raddr;
   logic [MODE_W-1:0]       mt_rdata;
   intra_pkg::state_t       dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   intra_mode_saver dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sads      (sads),
      .mode_mask (mode_mask),
      .res       (res),
      .mbnumber  (mbnumber),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .done      (done),
      .mode      (mode),
      .min_sad   (min_sad),
      .err       (err),
      .mt_raddr  (mt_raddr),
      .mt_rdata  (mt_rdata),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [SBW-1:0]   exp_q[$];
   logic [RES_W-1:0] res_v;
   int               mt_model[int];
   int               n_checks = 0;
   int               n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sad_of(input logic [NM*SAD_W-1:0] s, input int m);
      return int'(s[m*SAD_W +: SAD_W]);
   endfunction

   // Smallest SAD among available modes, then the first mode carrying it.
   task automatic ref_pick(input logic [NM*SAD_W-1:0] s, input logic [NM-1:0] m,
                           output int md, output int sd);
      int avail[$];
      int mins[$];
      for (int i = 0; i < NM; i++) if (m[i]) avail.push_back(sad_of(s, i));
      if (avail.size() == 0) begin
         md = DEF_MODE;
         sd = sad_of(s, DEF_MODE);
      end else begin
         mins = avail.min();
         sd   = mins[0];
         md   = -1;
         for (int i = 0; i < NM; i++)
            if (md < 0 && m[i] && sad_of(s, i) == sd) md = i;
      end
   endtask

   function automatic logic [ROW_BITS-1:0] exp_row(input int md, input int r);
      return res_v[(md * BLK * BLK + r * BLK) * PIX_W +: ROW_BITS];
   endfunction

   function automatic logic [ADDR_W-1:0] exp_addr(input int mb, input int r);
      return ADDR_W'(((mb / MB_COLS) * BLK + r) * MB_COLS + (mb % MB_COLS));
   endfunction

   function automatic logic [NM*SAD_W-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [NM*SAD_W-1:0] v;
      v[0*SAD_W +: SAD_W] = SAD_W'(a);
      v[1*SAD_W +: SAD_W] = SAD_W'(b);
      v[2*SAD_W +: SAD_W] = SAD_W'(c);
      v[3*SAD_W +: SAD_W] = SAD_W'(d);
      return v;
   endfunction

   task automatic rand_res();
      for (int i = 0; i < RES_W / 32; i++) res_v[i*32 +: 32] = $urandom;
   endtask

   // ---------------- driver tasks ----------------
   // Call right after a falling edge. Presents one block, waits for acceptance,
   // then follows it to done checking every row write and the result.
   task automatic run_block(input logic [NM*SAD_W-1:0] s, input logic [NM-1:0] m,
                            input int mb, input bit keep_valid, input int exp_wait,
                            input string tag);
      int             md, sd, waited, nwr;
      bit             is_err, got_done;
      logic [SBW-1:0] got, exp;
      rand_res();
      ref_pick(s, m, md, sd);
      is_err = (mb >= MB_COUNT);
      exp_q.delete();
      if (!is_err) for (int r = 0; r < BLK; r++) exp_q.push_back({exp_addr(mb, r), exp_row(md, r)});
      sads      = s;
      mode_mask = m;
      mbnumber  = (MB_W + 1)'(mb);
      res       = res_v;
      in_valid  = 1'b1;
      waited    = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_eq({tag, "_accept_wait"}, waited, exp_wait);
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
      got_done = 1'b0;
      nwr      = 0;
      for (int c = 1; c <= 40 && !got_done; c++) begin
         @(negedge clk);
         if (mem_we) begin
            nwr++;
            got = {mem_addr, mem_wdata};
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               check_eq({tag, "_row"}, got, exp);
            end
         end
         if (done) begin
            got_done = 1'b1;
            check_eq({tag, "_done_cycle"}, c, is_err ? NM + 1 : NM + BLK + 1);
            check_eq({tag, "_mode"}, mode, md);
            check_eq({tag, "_min_sad"}, min_sad, sd);
            check_eq({tag, "_err"}, err, is_err);
         end
      end
      if (!got_done) check_eq({tag, "_done_timeout"}, 0, 1);
      check_eq({tag, "_nwrites"}, nwr, is_err ? 0 : BLK);
      if (!is_err && got_done) mt_model[mb] = md;
   endtask

   task automatic post_idle(input string tag);
      @(negedge clk);
      check_eq({tag, "_in_ready"}, in_ready, 1);
      check_eq({tag, "_done_low"}, done, 0);
      check_eq({tag, "_we_low"}, mem_we, 0);
   endtask

   task automatic mt_check(input int a, input string tag);
      mt_raddr = MB_W'(a);
      @(posedge clk);
      @(negedge clk);
      check_eq(tag, mt_rdata, mt_model[a]);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int             nwr, ndone, mbr;
      logic [NM*SAD_W-1:0] rs;
      logic [SBW-1:0] got, exp;
      reset     = 1'b0;
      in_valid  = 1'b0;
      sads      = '0;
      mode_mask = '0;
      mbnumber  = '0;
      res       = '0;
      mt_raddr  = '0;
      res_v     = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_mode", mode, 0);
      check_eq("rst_min_sad", min_sad, 0);
      check_eq("rst_mt_rdata", mt_rdata, 0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      run_block(pack4(40, 30, 30, 50), 4'b1111, 33, 1'b0, 0, "tie");
      check_eq("tie_const_mode", mode, 1);
      check_eq("tie_const_sad", min_sad, 30);
      post_idle("tie");
      run_block(pack4(5, 9, 7, 3), 4'b0110, 40, 1'b0, 0, "mask");
      check_eq("mask_const_mode", mode, 2);
      post_idle("mask");
      run_block(pack4(1, 2, 60, 3), 4'b0000, 41, 1'b0, 0, "nomask");
      check_eq("nomask_const_sad", min_sad, 60);
      post_idle("nomask");
      run_block(pack4(9, 8, 7, 6), 4'b1111, 1024, 1'b0, 0, "range");
      post_idle("range");
      mt_check(33, "range_mt33_kept");

      // Back-to-back with in_valid held high
      run_block(pack4(3, 2, 1, 0), 4'b0111, 0, 1'b1, 0, "b2b0");
      run_block(pack4(0, 9, 9, 9), 4'b1001, 1, 1'b0, 1, "b2b1");
      post_idle("b2b");
      mt_check(0, "b2b_mt0");
      mt_check(1, "b2b_mt1");

      // Randomised blocks
      for (int i = 0; i < 14; i++) begin
         mbr = ($urandom_range(0, 7) == 0) ? $urandom_range(1024, 2047) : $urandom_range(0, 1023);
         run_block(pack4($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31)),
                   NM'($urandom_range(0, 15)), mbr, 1'b0, 0, "rnd");
         post_idle("rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset in the third WRITE cycle of a block whose table entry is known
      run_block(pack4(9, 9, 9, 1), 4'b1111, 5, 1'b0, 0, "pre_rst");
      post_idle("pre_rst");
      rand_res();
      rs = pack4(0, 9, 9, 9);
      exp_q.delete();
      for (int r = 0; r < BLK; r++) exp_q.push_back({exp_addr(5, r), exp_row(0, r)});
      sads      = rs;
      mode_mask = 4'b1111;
      mbnumber  = (MB_W + 1)'(5);
      res       = res_v;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      nwr = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_we) begin
            nwr++;
            got = {mem_addr, mem_wdata};
            exp = exp_q.pop_front();
            check_eq("midrst_row", got, exp);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midrst_nwrites", nwr, 2);
      check_eq("midrst_we", mem_we, 0);
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_mode", mode, 0);
      check_eq("midrst_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      nwr   = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (mem_we) nwr++;
      end
      check_eq("midrst_no_done", ndone, 0);
      check_eq("midrst_no_more_writes", nwr, 0);
      check_eq("midrst_idle", in_ready, 1);
      mt_check(5, "midrst_mt5_kept");

      // Whole mode table against the model
      foreach (mt_model[k]) mt_check(k, "mt_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/intra_mode_saver.md
# intra_mode_saver

Parametrised successor to the chroma 8x8 mode saver in the IntraPred path. Per block it selects the lowest-SAD prediction mode among NMODES candidates, honouring a per-block availability mask. It writes the selected residue block into a frame residue memory one row per cycle over a write port, and records the mode in an internal per-block mode table with a registered read port. It sits between the SAD/residue generators and the transform/entropy stage, for luma or chroma at any power-of-two block size.

## Interface
- BLK, 8, block edge in pixels (power of two, 4..16)
- NMODES, 4, candidate modes (2..9)
- SAD_W, 16, SAD width
- PIX_W, 8, residue pixel width
- FRAME_W, 256, frame width in pixels (multiple of BLK; FRAME_W/BLK a power of two)
- FRAME_H, 256, frame height in pixels (multiple of BLK)
- DEFAULT_MODE, 2, mode used when mask is all zero (DC)
- Derived: MB_COLS=FRAME_W/BLK, MB_COUNT=MB_COLS*FRAME_H/BLK, MODE_W=clog2(NMODES), MB_W=clog2(MB_COUNT), ADDR_W=clog2(FRAME_H*MB_COLS)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  block candidate set valid
- in_ready  out  1  high only in IDLE
- sads  in  NMODES*SAD_W  SAD of mode m at [m*SAD_W +: SAD_W]
- mode_mask  in  NMODES  bit m=1: mode m available
- res  in  NMODES*BLK*BLK*PIX_W  residue of mode m, pixel p=r*BLK+c, at [(m*BLK*BLK+p)*PIX_W +: PIX_W]
- mbnumber  in  MB_W+1  raster block index
- mem_we  out  1  residue row write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  BLK*PIX_W  pixel c at [c*PIX_W +: PIX_W]
- done  out  1  one-cycle pulse, block finished
- mode  out  MODE_W  selected mode; valid when done
- min_sad  out  SAD_W  winning SAD; valid when done
- err  out  1  one-cycle pulse with done: mbnumber out of range
- mt_raddr  in  MB_W  mode table read address
- mt_rdata  out  MODE_W  registered mode table read data

## Operation
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch sads, mode_mask, mbnumber; go to SCAN. res is not latched; the producer holds res stable from acceptance until done.
- SCAN: counter k=0..NMODES-1, one candidate per cycle. Candidate replaces best iff mask[k] && (no best yet || sad[k] < best). Strict less-than, so ties go to the lowest index. After k=NMODES-1: if no candidate was available, mode=DEFAULT_MODE and min_sad=sads[DEFAULT_MODE]. If mbnumber >= MB_COUNT, go to DONE with err set; otherwise go to WRITE.
- WRITE: row counter r=0..BLK-1. Each cycle: mem_we=1, mem_addr=(by*BLK+r)*MB_COLS+bx, where by=mbnumber/MB_COLS and bx=mbnumber%MB_COLS (shift/mask only). mem_wdata = row r of res[mode]. After r=BLK-1, go to DONE.
- DONE: done=1, err per above. Mode table [mbnumber] <= mode unless err. Return to IDLE.
- Mode table has MB_COUNT x MODE_W entries and is not reset; only written entries are defined. A read of the address being written in the same cycle returns the old value.
- Unsigned SAD compare. No arithmetic on residues.

## Timing
- Reset values: in_ready=1 (IDLE), mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, mode=0, min_sad=0, mt_rdata=0.
- Accept at cycle T. SCAN runs T+1..T+NMODES. WRITE runs T+NMODES+1..T+NMODES+BLK. done at T+NMODES+BLK+1. in_ready rises at T+NMODES+BLK+2.
- Throughput: one block per NMODES+BLK+2 cycles. On err, WRITE is skipped and done arrives at T+NMODES+1.
- mode and min_sad hold their values until the next done.
- mt_rdata reflects mt_raddr with one cycle of latency, independent of the FSM.
- Reset asserted mid-block: immediate return to IDLE, all outputs to reset values, no further writes. Rows already written remain, and the mode table is not updated.

## Structure
- Package intra_pkg: state enum, mode constants (V=0, H=1, DC=2, PLANE=3), clog2-based width helpers.
- Sub-module intra_sad_argmin: sequential masked argmin over NMODES (counter, best register, tie rule, default fallback), reusable by the 4x4/16x16 savers.
- Top: FSM, address generator, row mux, mode table.

## Test plan
- BLK=8, NMODES=4, sads={40,30,30,50}, mask=1111, mbnumber=33 -> mode=1, min_sad=30. Rows written at addr (8+r)*32+1 for r=0..7. done at T+13.
- sads={5,9,7,3}, mask=0110 -> mode=2, min_sad=7. Disabled modes are ignored.
- mask=0000, sads={1,2,60,3} -> mode=DEFAULT_MODE=2, min_sad=60.
- mbnumber=1024 (MB_COUNT=1024) -> no mem_we, done and err at T+5, mode table unchanged.
- Back-to-back blocks 0 and 1 with in_valid held high -> second accept at T+14. Then mt_raddr=0 and 1 return the respective modes one cycle later.
- reset low at the 3rd WRITE cycle -> exactly 2 rows written, no done, mode table entry unchanged, in_ready=1 after release.
